pll_drp_reconfig: RTL and testbench
===================================

# pll_drp_reconfig

Runtime reconfiguration sequencer for the 7-series PLLE2_ADV clock generator. It accepts a requested feedback multiplier, CLKOUT0 divider and input divider, and holds the PLL in reset while it rewrites the five counter registers over the Dynamic Reconfiguration Port (DRP) using read-modify-write. It then releases the PLL reset, waits for lock, and reports done or error. It sits beside the PLL wrapper, between the core's video/audio clock-select logic and the PLL DRP/RST/LOCKED pins.

## Interface
Clocking and reset: single clock `refclk`; reset `rst` is synchronous, active-high.

Parameters:
- `DRDY_TIMEOUT`, default 255: maximum `refclk` cycles to wait for `drp_drdy` per DRP access.
- `LOCK_TIMEOUT`, default 1048575: maximum cycles to wait for `pll_locked` after releasing reset.

Ports:
- `refclk` in 1: clock; also drives the DRP DCLK.
- `rst` in 1: synchronous active-high reset.
- `cfg_valid` in 1: request strobe; accepted when `cfg_ready`=1.
- `cfg_mult` in 7: CLKFBOUT_MULT; legal range 2..64.
- `cfg_div0` in 8: CLKOUT0_DIVIDE; legal range 1..128.
- `cfg_divclk` in 6: DIVCLK_DIVIDE; legal range 1..56.
- `cfg_ready` out 1: idle, able to accept a request.
- `cfg_done` out 1: one-cycle pulse on successful completion.
- `cfg_err` out 1: one-cycle pulse on an illegal request or a timeout.
- `pll_rst` out 1: PLL RST pin.
- `pll_locked` in 1: PLL LOCKED pin.
- `drp_daddr` out 7: DRP address.
- `drp_den` out 1: DRP enable.
- `drp_dwe` out 1: DRP write enable.
- `drp_di` out 16: DRP write data.
- `drp_do` in 16: DRP read data.
- `drp_drdy` in 1: DRP ready.

## Operation
- States: IDLE, RST_PLL, RD, RD_WAIT, WR, WR_WAIT, RELEASE, LOCK_WAIT.
- **IDLE:** `cfg_ready`=1, `pll_rst`=0.
  - On `cfg_valid`, the block latches all cfg fields.
  - If any field is out of range, it pulses `cfg_err` next cycle and stays in IDLE with no DRP or `pll_rst` activity.
  - Otherwise it goes to RST_PLL.
- **RST_PLL:** drives `pll_rst`=1, sets index i=0, then goes to RD. `pll_rst` stays 1 through all DRP states.
- **Register list** (i = 0..4):
  - 0x08 = CLKOUT0 ClkReg1
  - 0x09 = CLKOUT0 ClkReg2
  - 0x14 = CLKFBOUT ClkReg1
  - 0x15 = CLKFBOUT ClkReg2
  - 0x16 = DivReg
- **RD:** one-cycle `drp_den`=1, `drp_dwe`=0, `drp_daddr`=list[i]. Then RD_WAIT.
- **RD_WAIT:** on `drp_drdy`, latches `(drp_do & keep_mask) | new_bits` and goes to WR.
- **WR:** one-cycle `drp_den`=1, `drp_dwe`=1, `drp_di`=merged word. Then WR_WAIT.
- **WR_WAIT:** on `drp_drdy`, sets i+1. Goes to RD if i<4, else RELEASE.
- **Divider encoding** for value D (6-bit fields store 64 as 0):
  - If D=1: NO_COUNT=1, HIGH=1, LOW=1, EDGE=0.
  - Otherwise: HIGH=D>>1, LOW=D−HIGH, EDGE=D[0], NO_COUNT=0.
- **ClkReg1 layout:** [15:13] PHASE_MUX=0, [12] preserved, [11:6] HIGH, [5:0] LOW. keep_mask=0x1000.
- **ClkReg2 layout:** [15:8] preserved, [7] EDGE, [6] NO_COUNT, [5:0] DELAY_TIME=0. keep_mask=0xFF00.
- **DivReg layout:** [15:14] preserved, [13] EDGE, [12] NO_COUNT, [11:6] HIGH, [5:0] LOW. keep_mask=0xC000.
- Lock and loop-filter registers are not touched. Callers stay within a multiplier band qualified for the static filter settings.
- **RELEASE:** `pll_rst`←0, then LOCK_WAIT.
- **LOCK_WAIT:** `pll_locked`=1 → pulse `cfg_done`, go to IDLE.
- **DRDY timeout** (counter reaches DRDY_TIMEOUT in RD_WAIT/WR_WAIT): pulse `cfg_err`, keep `pll_rst`=1, go to IDLE with `pll_rst` held until the next accepted request completes.
  - IDLE drives `pll_rst` from a sticky fault flag, cleared on the next successful RELEASE.
- **Lock timeout:** pulse `cfg_err`, `pll_rst` stays 0, go to IDLE.
- `drp_drdy` outside RD_WAIT/WR_WAIT is ignored.

## Timing
- **Reset values** (during `rst`): state IDLE, `pll_rst`=1, `cfg_ready`=0, `cfg_done`=0, `cfg_err`=0, `drp_den`=0, `drp_dwe`=0, `drp_daddr`=0, `drp_di`=0, fault flag cleared.
  - First cycle after `rst` deasserts: `cfg_ready`=1, `pll_rst`=0.
- **Accept cycle N** (`cfg_valid` & `cfg_ready`):
  - `cfg_ready`=0 and `pll_rst`=1 at N+1.
  - First `drp_den` at N+2.
- `drp_den` and `drp_dwe` are always exactly one cycle wide.
- With zero-wait DRDY (DRDY the cycle after DEN), each register takes 4 cycles. Last write DRDY at N+21, `pll_rst`=0 at N+22.
- `cfg_done` and `cfg_ready` rise together the cycle after `pll_locked` is first sampled high in LOCK_WAIT.
- **Illegal request:** `cfg_err` pulses at N+1. `cfg_ready` stays 1 throughout.
- **`rst` mid-sequence:** aborts on the next edge. DEN/DWE go low, no further DRP access, reset values apply.

## Test plan
- Reset, then request mult=32, div0=80, divclk=1 with a DRP model returning 0xFFFF and 1-cycle DRDY. Required writes:
  - 0x08 ← 0x1A28
  - 0x09 ← 0xFF00
  - 0x14 ← 0x1410
  - 0x15 ← 0xFF00
  - 0x16 ← 0xD041
  - Then `pll_rst` falls; raise `pll_locked` after 100 cycles → `cfg_done` pulse.
- Request div0=1, div0=128, div0=7:
  - div0=1: ClkReg2 bit6=1, ClkReg1[11:0]=0x041.
  - div0=128: ClkReg1[11:0]=0x000.
  - div0=7: HIGH=3, LOW=4, EDGE=1.
- Illegal requests mult=1, div0=0, divclk=57: each → `cfg_err` at N+1, no `drp_den`, `pll_rst` stays 0.
- Hold `drp_drdy` low after the first read → `cfg_err` after 255 cycles, `pll_rst` held 1. A retry with a good DRP model completes and drops `pll_rst`.
- Never assert `pll_locked` → `cfg_err` at LOCK_TIMEOUT (use 1000 in the bench), `pll_rst`=0, `cfg_ready`=1.
- Assert `rst` during WR_WAIT of register 2 → `drp_den` stays 0, reset values apply, a spurious `drp_drdy` is ignored, and a new request succeeds.

Source files
------------

// File: rtl/pll_drp_reconfig.sv
// Runtime reconfiguration sequencer for a PLLE2_ADV: holds the PLL in reset, rewrites the
// CLKOUT0/CLKFBOUT/DIVCLK counter registers over DRP by read-modify-write, then waits for lock.
//
//   state      | meaning
//   -----------+------------------------------------------------------------
//   IDLE       | ready for a request; pll_rst follows the sticky fault flag
//   RST_PLL    | PLL held in reset, register walk about to start
//   RD         | one-cycle DRP read strobe of the current register
//   RD_WAIT    | waiting for read DRDY, merge new fields into the read word
//   WR         | one-cycle DRP write strobe with the merged word
//   WR_WAIT    | waiting for write DRDY, advance to next register or release
//   RELEASE    | PLL reset dropped
//   LOCK_WAIT  | waiting for LOCKED or the lock timeout
module pll_drp_reconfig #(
    parameter int DRDY_TIMEOUT = 255,
    parameter int LOCK_TIMEOUT = 1048575
) (
    input  logic        refclk,
    input  logic        rst,
    input  logic        cfg_valid,
    input  logic [6:0]  cfg_mult,
    input  logic [7:0]  cfg_div0,
    input  logic [5:0]  cfg_divclk,
    output logic        cfg_ready,
    output logic        cfg_done,
    output logic        cfg_err,
    output logic        pll_rst,
    input  logic        pll_locked,
    output logic [6:0]  drp_daddr,
    output logic        drp_den,
    output logic        drp_dwe,
    output logic [15:0] drp_di,
    input  logic [15:0] drp_do,
    input  logic        drp_drdy
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_RST_PLL   = 3'd1;
    localparam logic [2:0] S_RD        = 3'd2;
    localparam logic [2:0] S_RD_WAIT   = 3'd3;
    localparam logic [2:0] S_WR        = 3'd4;
    localparam logic [2:0] S_WR_WAIT   = 3'd5;
    localparam logic [2:0] S_RELEASE   = 3'd6;
    localparam logic [2:0] S_LOCK_WAIT = 3'd7;

    localparam logic [2:0] LAST_IDX = 3'd4;

    // One shared down-counter serves both the DRDY and the lock timeouts.
    localparam int TMAX = (LOCK_TIMEOUT > DRDY_TIMEOUT) ? LOCK_TIMEOUT : DRDY_TIMEOUT;
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [TW-1:0] DRDY_LOAD = TW'(DRDY_TIMEOUT - 1);
    localparam logic [TW-1:0] LOCK_LOAD = TW'(LOCK_TIMEOUT - 1);

    logic [2:0]    state;
    logic [2:0]    idx;
    logic [TW-1:0] timer;
    logic          fault;
    logic [6:0]    mult_q;
    logic [7:0]    div0_q;
    logic [5:0]    divclk_q;

    logic          cfg_legal;
    logic [13:0]   enc_out;
    logic [13:0]   enc_fb;
    logic [13:0]   enc_dc;
    logic [15:0]   keep_mask;
    logic [15:0]   new_bits;
    logic [15:0]   merged;

    // Counter encoding packed as {EDGE, NO_COUNT, HIGH[5:0], LOW[5:0]}; a count of 64 wraps to 0.
    function automatic logic [13:0] enc_div(input logic [7:0] d);
        if (d == 8'd1) begin
            return {1'b0, 1'b1, 6'd1, 6'd1};
        end
        return {d[0], 1'b0, 6'(d >> 1), 6'(d - (d >> 1))};
    endfunction

    function automatic logic [6:0] reg_addr(input logic [2:0] i);
        case (i)
            3'd0:    return 7'h08;
            3'd1:    return 7'h09;
            3'd2:    return 7'h14;
            3'd3:    return 7'h15;
            3'd4:    return 7'h16;
            default: return 7'h00;
        endcase
    endfunction

    assign cfg_legal = (cfg_mult >= 7'd2) && (cfg_mult <= 7'd64) &&
                       (cfg_div0 >= 8'd1) && (cfg_div0 <= 8'd128) &&
                       (cfg_divclk >= 6'd1) && (cfg_divclk <= 6'd56);

    always_comb begin
        enc_out   = enc_div(div0_q);
        enc_fb    = enc_div({1'b0, mult_q});
        enc_dc    = enc_div({2'b00, divclk_q});
        keep_mask = 16'h0000;
        new_bits  = 16'h0000;
        case (idx)
            3'd0: begin
                keep_mask = 16'h1000;
                new_bits  = {4'b0000, enc_out[11:0]};
            end
            3'd1: begin
                keep_mask = 16'hFF00;
                new_bits  = {8'h00, enc_out[13:12], 6'b000000};
            end
            3'd2: begin
                keep_mask = 16'h1000;
                new_bits  = {4'b0000, enc_fb[11:0]};
            end
            3'd3: begin
                keep_mask = 16'hFF00;
                new_bits  = {8'h00, enc_fb[13:12], 6'b000000};
            end
            3'd4: begin
                keep_mask = 16'hC000;
                new_bits  = {2'b00, enc_dc};
            end
            default: begin
                keep_mask = 16'h0000;
                new_bits  = 16'h0000;
            end
        endcase
        merged = (drp_do & keep_mask) | new_bits;
    end

    // Outputs are registered from the transition being taken, so every strobe is one cycle wide.
    always_ff @(posedge refclk) begin
        if (rst) begin
            state     <= S_IDLE;
            idx       <= 3'd0;
            timer     <= '0;
            fault     <= 1'b0;
            mult_q    <= 7'd0;
            div0_q    <= 8'd0;
            divclk_q  <= 6'd0;
            pll_rst   <= 1'b1;
            cfg_ready <= 1'b0;
            cfg_done  <= 1'b0;
            cfg_err   <= 1'b0;
            drp_den   <= 1'b0;
            drp_dwe   <= 1'b0;
            drp_daddr <= 7'd0;
            drp_di    <= 16'd0;
        end else begin
            cfg_done <= 1'b0;
            cfg_err  <= 1'b0;
            drp_den  <= 1'b0;
            drp_dwe  <= 1'b0;
            case (state)
                S_IDLE: begin
                    cfg_ready <= 1'b1;
                    pll_rst   <= fault;
                    if (cfg_valid && cfg_ready) begin
                        mult_q   <= cfg_mult;
                        div0_q   <= cfg_div0;
                        divclk_q <= cfg_divclk;
                        idx      <= 3'd0;
                        if (cfg_legal) begin
                            state     <= S_RST_PLL;
                            cfg_ready <= 1'b0;
                            pll_rst   <= 1'b1;
                        end else begin
                            cfg_err <= 1'b1;
                        end
                    end
                end
                S_RST_PLL: begin
                    state     <= S_RD;
                    drp_den   <= 1'b1;
                    drp_daddr <= reg_addr(idx);
                end
                S_RD: begin
                    state <= S_RD_WAIT;
                    timer <= DRDY_LOAD;
                end
                S_RD_WAIT: begin
                    if (drp_drdy) begin
                        state   <= S_WR;
                        drp_den <= 1'b1;
                        drp_dwe <= 1'b1;
                        drp_di  <= merged;
                    end else if (timer == '0) begin
                        state     <= S_IDLE;
                        cfg_err   <= 1'b1;
                        cfg_ready <= 1'b1;
                        fault     <= 1'b1;
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end
                S_WR: begin
                    state <= S_WR_WAIT;
                    timer <= DRDY_LOAD;
                end
                S_WR_WAIT: begin
                    if (drp_drdy) begin
                        if (idx == LAST_IDX) begin
                            state   <= S_RELEASE;
                            pll_rst <= 1'b0;
                            fault   <= 1'b0;
                        end else begin
                            idx       <= idx + 3'd1;
                            state     <= S_RD;
                            drp_den   <= 1'b1;
                            drp_daddr <= reg_addr(idx + 3'd1);
                        end
                    end else if (timer == '0) begin
                        state     <= S_IDLE;
                        cfg_err   <= 1'b1;
                        cfg_ready <= 1'b1;
                        fault     <= 1'b1;
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end
                S_RELEASE: begin
                    state <= S_LOCK_WAIT;
                    timer <= LOCK_LOAD;
                end
                S_LOCK_WAIT: begin
                    if (pll_locked) begin
                        state     <= S_IDLE;
                        cfg_done  <= 1'b1;
                        cfg_ready <= 1'b1;
                    end else if (timer == '0) begin
                        state     <= S_IDLE;
                        cfg_err   <= 1'b1;
                        cfg_ready <= 1'b1;
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    cfg_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pll_drp_reconfig.sv
// Directed bench for pll_drp_reconfig with a one-cycle-latency DRP responder and hand-computed
// register images for each request.
module tb_pll_drp_reconfig;

    logic        refclk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_valid = 1'b0;
    logic [6:0]  cfg_mult = 7'd0;
    logic [7:0]  cfg_div0 = 8'd0;
    logic [5:0]  cfg_divclk = 6'd0;
    logic        cfg_ready, cfg_done, cfg_err, pll_rst;
    logic        pll_locked = 1'b0;
    logic [6:0]  drp_daddr;
    logic        drp_den, drp_dwe;
    logic [15:0] drp_di;
    logic [15:0] drp_do;
    logic        drp_drdy;

    logic        model_drdy;
    logic [15:0] model_do;
    logic        spur_drdy = 1'b0;
    logic        drdy_en = 1'b1;
    logic [15:0] rd_value = 16'hFFFF;
    logic        den_prev;
    int          wr_cnt, den_cnt, den_wide, dwe_bad;
    logic [6:0]  wr_addr [0:63];
    logic [15:0] wr_data [0:63];

    int vectors = 0;
    int miscompares = 0;
    int base, dc0, k;

    assign drp_drdy = model_drdy | spur_drdy;
    assign drp_do   = model_do;

    pll_drp_reconfig #(.DRDY_TIMEOUT(255), .LOCK_TIMEOUT(1000)) dut (
        .refclk(refclk), .rst(rst), .cfg_valid(cfg_valid), .cfg_mult(cfg_mult),
        .cfg_div0(cfg_div0), .cfg_divclk(cfg_divclk), .cfg_ready(cfg_ready),
        .cfg_done(cfg_done), .cfg_err(cfg_err), .pll_rst(pll_rst), .pll_locked(pll_locked),
        .drp_daddr(drp_daddr), .drp_den(drp_den), .drp_dwe(drp_dwe), .drp_di(drp_di),
        .drp_do(drp_do), .drp_drdy(drp_drdy)
    );

    initial forever #5 refclk = ~refclk;

    // DRP responder: DRDY the cycle after DEN; reads return rd_value; writes are logged.
    always @(posedge refclk) begin
        model_drdy <= drdy_en && drp_den;
        if (drp_den && !drp_dwe) model_do <= rd_value;
        if (drp_den && drp_dwe) begin
            wr_addr[wr_cnt[5:0]] <= drp_daddr;
            wr_data[wr_cnt[5:0]] <= drp_di;
            wr_cnt <= wr_cnt + 1;
        end
        if (drp_den) den_cnt <= den_cnt + 1;
        if (drp_den && den_prev) den_wide <= den_wide + 1;
        if (drp_dwe && !drp_den) dwe_bad <= dwe_bad + 1;
        den_prev <= drp_den;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge refclk);
    endtask

    // Drives the request during cycle N; returns at the negedge of N+1.
    task automatic req(input logic [6:0] m, input logic [7:0] d0, input logic [5:0] dc);
        cfg_mult = m;
        cfg_div0 = d0;
        cfg_divclk = dc;
        cfg_valid = 1'b1;
        @(negedge refclk);
        cfg_valid = 1'b0;
    endtask

    // From N+1 of an accepted request with a zero-wait DRP through the done pulse.
    task automatic run_ok(input int lock_delay);
        chk("ready_n1", cfg_ready, 1'b0);
        chk("pllrst_n1", pll_rst, 1'b1);
        tick(1);
        chk("den_n2", drp_den, 1'b1);
        chk("dwe_n2", drp_dwe, 1'b0);
        chk("daddr_n2", drp_daddr, 7'h08);
        tick(19);
        chk("pllrst_n21", pll_rst, 1'b1);
        tick(1);
        chk("pllrst_n22", pll_rst, 1'b0);
        tick(lock_delay);
        pll_locked = 1'b1;
        tick(1);
        chk("done", cfg_done, 1'b1);
        chk("ready_with_done", cfg_ready, 1'b1);
        pll_locked = 1'b0;
        tick(1);
        chk("done_width", cfg_done, 1'b0);
    endtask

    task automatic check_writes(input int b, input logic [15:0] e0, input logic [15:0] e1,
                                input logic [15:0] e2, input logic [15:0] e3, input logic [15:0] e4);
        logic [15:0] ed [5];
        logic [6:0]  ea [5];
        ed = '{e0, e1, e2, e3, e4};
        ea = '{7'h08, 7'h09, 7'h14, 7'h15, 7'h16};
        chk("wr_count", wr_cnt - b, 5);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("wr_addr%0d", i), wr_addr[b + i], ea[i]);
            chk($sformatf("wr_data%0d", i), wr_data[b + i], ed[i]);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tick(3);
        chk("rst_pllrst", pll_rst, 1'b1);
        chk("rst_ready", cfg_ready, 1'b0);
        chk("rst_done", cfg_done, 1'b0);
        chk("rst_err", cfg_err, 1'b0);
        chk("rst_den", drp_den, 1'b0);
        chk("rst_dwe", drp_dwe, 1'b0);
        chk("rst_daddr", drp_daddr, 7'h00);
        chk("rst_di", drp_di, 16'h0000);
        rst = 1'b0;
        tick(1);
        chk("post_rst_ready", cfg_ready, 1'b1);
        chk("post_rst_pllrst", pll_rst, 1'b0);
        tick(2);

        // mult=32 div0=80 divclk=1 over an all-ones DRP image
        base = wr_cnt;
        req(7'd32, 8'd80, 6'd1);
        run_ok(100);
        check_writes(base, 16'h1A28, 16'hFF00, 16'h1410, 16'hFF00, 16'hD041);
        tick(2);

        base = wr_cnt;
        req(7'd32, 8'd1, 6'd1);
        run_ok(5);
        chk("div1_reg1", wr_data[base][11:0], 12'h041);
        chk("div1_nocount", wr_data[base + 1][6], 1'b1);
        tick(2);

        base = wr_cnt;
        req(7'd32, 8'd128, 6'd1);
        run_ok(5);
        chk("div128_reg1_low", wr_data[base][11:0], 12'h000);
        chk("div128_reg1", wr_data[base], 16'h1000);
        tick(2);

        // div0=7 divclk=5 over a 0x5A5A image exercises the keep masks
        rd_value = 16'h5A5A;
        base = wr_cnt;
        req(7'd32, 8'd7, 6'd5);
        run_ok(5);
        check_writes(base, 16'h10C4, 16'h5A80, 16'h1410, 16'h5A00, 16'h6083);
        rd_value = 16'hFFFF;
        tick(2);

        dc0 = den_cnt;
        req(7'd1, 8'd80, 6'd1);
        chk("ill_mult_err", cfg_err, 1'b1);
        chk("ill_mult_ready", cfg_ready, 1'b1);
        chk("ill_mult_pllrst", pll_rst, 1'b0);
        tick(1);
        chk("ill_mult_errw", cfg_err, 1'b0);
        req(7'd32, 8'd0, 6'd1);
        chk("ill_div0_err", cfg_err, 1'b1);
        chk("ill_div0_ready", cfg_ready, 1'b1);
        tick(1);
        req(7'd32, 8'd80, 6'd57);
        chk("ill_divclk_err", cfg_err, 1'b1);
        chk("ill_divclk_ready", cfg_ready, 1'b1);
        tick(3);
        chk("ill_no_den", den_cnt - dc0, 0);
        chk("ill_pllrst", pll_rst, 1'b0);

        // DRP never answers the first read
        drdy_en = 1'b0;
        dc0 = den_cnt;
        req(7'd32, 8'd80, 6'd1);
        tick(1);
        chk("to_den", drp_den, 1'b1);
        tick(1);
        k = 0;
        while (!cfg_err && k < 400) begin
            tick(1);
            k++;
        end
        chk("drdy_to_latency", k, 255);
        chk("drdy_to_pllrst", pll_rst, 1'b1);
        chk("drdy_to_ready", cfg_ready, 1'b1);
        tick(5);
        chk("fault_hold_pllrst", pll_rst, 1'b1);
        chk("to_single_den", den_cnt - dc0, 1);

        drdy_en = 1'b1;
        base = wr_cnt;
        req(7'd32, 8'd80, 6'd1);
        run_ok(10);
        check_writes(base, 16'h1A28, 16'hFF00, 16'h1410, 16'hFF00, 16'hD041);
        tick(2);

        // PLL never locks
        req(7'd32, 8'd80, 6'd1);
        tick(21);
        chk("lt_pllrst_fall", pll_rst, 1'b0);
        k = 0;
        while (!cfg_err && k < 1200) begin
            tick(1);
            k++;
        end
        chk("lock_to_latency", k, 1001);
        chk("lock_to_pllrst", pll_rst, 1'b0);
        chk("lock_to_ready", cfg_ready, 1'b1);
        tick(2);

        // reset during WR_WAIT of register 2
        base = wr_cnt;
        req(7'd32, 8'd80, 6'd1);
        tick(12);
        chk("abort_writes_before", wr_cnt - base, 3);
        rst = 1'b1;
        tick(1);
        chk("abort_den", drp_den, 1'b0);
        chk("abort_pllrst", pll_rst, 1'b1);
        chk("abort_ready", cfg_ready, 1'b0);
        dc0 = den_cnt;
        spur_drdy = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(2);
        spur_drdy = 1'b0;
        chk("spur_no_den", den_cnt - dc0, 0);
        chk("spur_den", drp_den, 1'b0);
        chk("spur_ready", cfg_ready, 1'b1);
        chk("spur_pllrst", pll_rst, 1'b0);
        tick(1);
        base = wr_cnt;
        req(7'd32, 8'd80, 6'd1);
        run_ok(3);
        check_writes(base, 16'h1A28, 16'hFF00, 16'h1410, 16'hFF00, 16'hD041);

        chk("den_width", den_wide, 0);
        chk("dwe_without_den", dwe_bad, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
